// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
//   AXI4-Lite responder exposing NUM_REGS 32-bit read/write control registers.
//   Write and read channels run on independent two-state FSMs and never stall
//   each other. Register contents are driven out flat on regs_out, and every
//   accepted in-range write raises wr_pulse/wr_index for one cycle.
// Ports
//   ACLK, ARESETn           clock, synchronous active-low reset
//   AW*/W*/B*               AXI-Lite write address/data/response channels
//   AR*/R*                  AXI-Lite read address/data channels
//   regs_out                register k at [32k+31:32k]
//   wr_pulse, wr_index      one-cycle update strobe and the updated index
module axi_lite_slave_regs #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [31:0]           ARADDR,
  input  logic [2:0]            ARPROT,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic [32*NUM_REGS-1:0] regs_out,
  output logic                  wr_pulse,
  output logic [7:0]            wr_index
);

  localparam int          IDX_W = ADDR_W - 2;
  localparam logic [31:0] NREGS = NUM_REGS;
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [NUM_REGS-1:0][31:0] regs;

  // Zero-extended register index of a byte address.
  function automatic logic [31:0] idx_of(input logic [31:0] a);
    return {{(32-IDX_W){1'b0}}, a[ADDR_W-1:2]};
  endfunction

  // In range only when no bits above the decoded window are set and the
  // index falls inside the implemented bank.
  function automatic logic in_range(input logic [31:0] a);
    return (a[31:ADDR_W] == '0) && (idx_of(a) < NREGS);
  endfunction

  // ---------------- write channel ----------------
  wstate_t     wstate, wstate_nx;
  logic        awready_q, wready_q, aw_got, w_got;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        aw_hs, w_hs, commit, wr_ok;
  logic [31:0] aw_idx;

  // READY is only ever high in W_IDLE before its channel has been captured.
  assign aw_hs  = AWVALID && awready_q;
  assign w_hs   = WVALID && wready_q;
  assign commit = (wstate == W_IDLE) && aw_got && w_got;
  assign aw_idx = idx_of(aw_addr);
  assign wr_ok  = in_range(aw_addr);

  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_IDLE: if (commit) wstate_nx = W_RESP;
      W_RESP: if (BREADY) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wstate    <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      wr_pulse  <= 1'b0;
      wr_index  <= '0;
      regs      <= '0;
    end else begin
      wstate   <= wstate_nx;
      wr_pulse <= 1'b0;
      if (aw_hs) begin
        aw_addr   <= AWADDR;
        aw_got    <= 1'b1;
        awready_q <= 1'b0;
      end
      if (w_hs) begin
        w_data   <= WDATA;
        w_strb   <= WSTRB;
        w_got    <= 1'b1;
        wready_q <= 1'b0;
      end
      if (commit) begin
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
        wr_pulse <= wr_ok;
        wr_index <= 8'(aw_idx);
        for (int k = 0; k < NUM_REGS; k++)
          if (wr_ok && aw_idx == 32'(k))
            for (int b = 0; b < 4; b++)
              if (w_strb[b]) regs[k][8*b +: 8] <= w_data[8*b +: 8];
      end
      if (wstate == W_RESP && BREADY) begin
        bvalid_q  <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t     rstate, rstate_nx;
  logic        arready_q, rvalid_q, ar_hs, rd_ok;
  logic [31:0] rdata_q, rd_val, ar_idx;
  logic [1:0]  rresp_q;

  assign ar_hs  = ARVALID && arready_q;
  assign ar_idx = idx_of(ARADDR);
  assign rd_ok  = in_range(ARADDR);

  // Sampled from the pre-edge register contents, so a read captured on the
  // same edge as a write commit returns the old value.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (ar_idx == 32'(k)) rd_val = regs[k];
  end

  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE: if (ar_hs)  rstate_nx = R_DATA;
      R_DATA: if (RREADY) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rstate    <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      rstate <= rstate_nx;
      if (ar_hs) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_ok ? rd_val : 32'h0;
        rresp_q   <= rd_ok ? OKAY : SLVERR;
      end
      if (rstate == R_DATA && RREADY) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign regs_out = regs;

  // Protection bits and byte offsets carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, aw_addr[1:0], ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 5;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [32*NUM_REGS-1:0] regs_out;
  logic        wr_pulse;
  logic [7:0]  wr_index;

  axi_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  logic [32*NUM_REGS-1:0] exp_regs;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge ACLK);
  endtask

  // Called while BVALID should be up and BREADY high: pops the scoreboard.
  task automatic check_b(input string tag);
    logic [1:0] e;
    chk({tag, ".bvalid"}, 128'(BVALID), 128'(1'b1));
    if (bq.size() == 0) chk({tag, ".bq_empty"}, 128'(1), 128'(0));
    else begin
      e = bq.pop_front();
      chk({tag, ".bresp"}, 128'(BRESP), 128'(e));
    end
  endtask

  task automatic check_r(input string tag);
    rexp_t e;
    chk({tag, ".rvalid"}, 128'(RVALID), 128'(1'b1));
    if (rq.size() == 0) chk({tag, ".rq_empty"}, 128'(1), 128'(0));
    else begin
      e = rq.pop_front();
      chk({tag, ".rdata"}, 128'(RDATA), 128'(e.data));
      chk({tag, ".rresp"}, 128'(RRESP), 128'(e.resp));
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    AWVALID = 0; AWADDR = 0; AWPROT = 0; WVALID = 0; WDATA = 0; WSTRB = 0;
    BREADY = 0; ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;
    exp_regs = '0;
    repeat (3) cyc();
    chk("rst.awready", 128'(AWREADY), 128'(1));
    chk("rst.wready",  128'(WREADY),  128'(1));
    chk("rst.arready", 128'(ARREADY), 128'(1));
    chk("rst.bvalid",  128'(BVALID),  128'(0));
    chk("rst.rvalid",  128'(RVALID),  128'(0));
    chk("rst.regs",    128'(regs_out), 128'(0));
    chk("rst.pulse",   128'(wr_pulse), 128'(0));
    ARESETn = 1'b1;
    cyc();

    // 1: AW and W together
    AWVALID = 1; AWADDR = 32'h4; WVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    BREADY = 1; bq.push_back(2'b00);
    cyc();
    AWVALID = 0; WVALID = 0;
    chk("t1.awready_drop", 128'(AWREADY), 128'(0));
    chk("t1.wready_drop",  128'(WREADY),  128'(0));
    chk("t1.b_latency",    128'(BVALID),  128'(0));
    cyc();
    exp_regs[63:32] = 32'hDEADBEEF;
    check_b("t1");
    chk("t1.regs",   128'(regs_out), 128'(exp_regs));
    chk("t1.pulse",  128'(wr_pulse), 128'(1));
    chk("t1.index",  128'(wr_index), 128'(1));
    cyc();
    chk("t1.b_done",   128'(BVALID),   128'(0));
    chk("t1.pulse_1c", 128'(wr_pulse), 128'(0));
    chk("t1.awready",  128'(AWREADY),  128'(1));

    // 2: W first, AW three cycles later
    WVALID = 1; WDATA = 32'h12345678; WSTRB = 4'h5; bq.push_back(2'b00);
    cyc();
    WVALID = 0;
    chk("t2.wready_drop", 128'(WREADY),  128'(0));
    chk("t2.aw_waiting",  128'(AWREADY), 128'(1));
    cyc(); cyc();
    chk("t2.no_b_yet", 128'(BVALID), 128'(0));
    AWVALID = 1; AWADDR = 32'h0;
    cyc();
    AWVALID = 0;
    chk("t2.b_latency", 128'(BVALID), 128'(0));
    cyc();
    exp_regs[31:0] = 32'h00340078;
    check_b("t2");
    chk("t2.regs",  128'(regs_out), 128'(exp_regs));
    chk("t2.index", 128'(wr_index), 128'(0));
    cyc();

    // 3: read with RREADY held low for 4 cycles
    ARVALID = 1; ARADDR = 32'h4; RREADY = 0;
    rq.push_back('{data: 32'hDEADBEEF, resp: 2'b00});
    cyc();
    ARVALID = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3.hold%0d.rvalid", i),  128'(RVALID),  128'(1));
      chk($sformatf("t3.hold%0d.rdata", i),   128'(RDATA),   128'(32'hDEADBEEF));
      chk($sformatf("t3.hold%0d.arready", i), 128'(ARREADY), 128'(0));
      cyc();
    end
    RREADY = 1;
    check_r("t3");
    cyc();
    chk("t3.r_done",  128'(RVALID),  128'(0));
    chk("t3.arready", 128'(ARREADY), 128'(1));

    // 4: out-of-range write and read, issued together
    AWVALID = 1; AWADDR = 32'h10; WVALID = 1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
    ARVALID = 1; ARADDR = 32'h1C;
    bq.push_back(2'b10);
    rq.push_back('{data: 32'h0, resp: 2'b10});
    cyc();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    check_r("t4");
    cyc();
    check_b("t4");
    chk("t4.regs",  128'(regs_out), 128'(exp_regs));
    chk("t4.pulse", 128'(wr_pulse), 128'(0));
    cyc();
    chk("t4.pulse_after", 128'(wr_pulse), 128'(0));

    // 5: read of reg2 captured on the write-commit edge returns the old value
    AWVALID = 1; AWADDR = 32'h8; WVALID = 1; WDATA = 32'hAAAA5555; WSTRB = 4'hF;
    bq.push_back(2'b00);
    cyc();
    AWVALID = 0; WVALID = 0;
    ARVALID = 1; ARADDR = 32'h8;
    rq.push_back('{data: 32'h0, resp: 2'b00});
    cyc();
    ARVALID = 0;
    exp_regs[95:64] = 32'hAAAA5555;
    check_r("t5.old");
    check_b("t5");
    chk("t5.regs",  128'(regs_out), 128'(exp_regs));
    chk("t5.index", 128'(wr_index), 128'(2));
    cyc();
    ARVALID = 1; ARADDR = 32'h8;
    rq.push_back('{data: 32'hAAAA5555, resp: 2'b00});
    cyc();
    ARVALID = 0;
    check_r("t5.new");
    cyc();
    chk("t5.sb_empty", 128'(bq.size() + rq.size()), 128'(0));

    // 6: reset while both responses are pending
    BREADY = 0; RREADY = 0;
    AWVALID = 1; AWADDR = 32'hC; WVALID = 1; WDATA = 32'h11; WSTRB = 4'hF;
    ARVALID = 1; ARADDR = 32'h0;
    cyc();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    cyc();
    exp_regs[127:96] = 32'h11;
    chk("t6.bvalid_pend", 128'(BVALID), 128'(1));
    chk("t6.rvalid_pend", 128'(RVALID), 128'(1));
    chk("t6.regs_pre",    128'(regs_out), 128'(exp_regs));
    ARESETn = 0;
    cyc();
    exp_regs = '0;
    chk("t6.bvalid",  128'(BVALID),   128'(0));
    chk("t6.rvalid",  128'(RVALID),   128'(0));
    chk("t6.regs",    128'(regs_out), 128'(exp_regs));
    chk("t6.awready", 128'(AWREADY),  128'(1));
    chk("t6.wready",  128'(WREADY),   128'(1));
    chk("t6.arready", 128'(ARREADY),  128'(1));
    chk("t6.pulse",   128'(wr_pulse), 128'(0));
    ARESETn = 1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
